// File: rtl/fir_out_pkg.sv
// Shared types, default widths and constant helpers for the FIR output conditioner.
package fir_out_pkg;

    localparam int DEF_IN_W   = 32;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 7;
    localparam int DEF_SETTLE = 4;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN
    } state_t;

    // Half-LSB bias added before the right shift so the shift rounds to nearest.
    function automatic logic [63:0] rnd_bias(input int shift);
        return 64'd1 << (shift - 1);
    endfunction

    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO, DEPTH x W, combinational head read; DEPTH must be a power of 2 and >= 2.
module fir_out_fifo
    import fir_out_pkg::*;
#(
    parameter int W     = DEF_OUT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_wdata,
    output logic [W-1:0]           o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_push_ok,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_level   = r_level;
    assign w_pop     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign o_push_ok = i_push && (!o_full || w_pop);
    assign o_drop    = i_push && o_full && !w_pop;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({o_push_ok, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/fir_out_conditioner.sv
// FIR output conditioner: settle discard, round/rescale, saturate, decimate, FIFO out.
// Optional FIR_OUT_PEAK_EN adds a peak tracker on values written to the FIFO.
module fir_out_conditioner
    import fir_out_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int SETTLE = DEF_SETTLE,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [3:0]             dec_factor,
    input  logic                   clear_flags,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sat_flag,
    output logic                   ovf_flag,
    output logic [OUT_W-1:0]       peak_out
);

    localparam int SUM_W = IN_W + 1;
    localparam int SCW   = $clog2(SETTLE + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SCW-1:0]   r_settle_cnt;
    logic [3:0]       r_phase;
    logic [3:0]       r_dec_cur;
    logic [3:0]       w_dec_new;
    logic             w_keep;

    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_scaled;
    logic             w_sat;
    logic [OUT_W-1:0] w_y;

    logic             r_stg_vld;
    logic [OUT_W-1:0] r_stg_data;
    logic             r_stg_sat;
    logic             r_sat;
    logic             r_ovf;

    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_drop;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (!enable)
                    w_state_nxt = S_IDLE;
                else if (in_valid && r_settle_cnt == SCW'(SETTLE - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN:    if (!enable) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_SETTLE)
                r_settle_cnt <= '0;
            else if (in_valid && enable)
                r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    // Decimation factor is latched only when a sample is kept, so changes apply at the wrap.
    assign w_dec_new = (dec_factor == 4'd0) ? 4'd1 : dec_factor;
    assign w_keep    = (r_state == S_RUN) && enable && in_valid && (r_phase == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= '0;
            r_dec_cur <= 4'd1;
        end else if (r_state != S_RUN) begin
            r_phase   <= '0;
            r_dec_cur <= 4'd1;
        end else if (in_valid && enable) begin
            if (r_phase == 4'd0) begin
                r_dec_cur <= w_dec_new;
                r_phase   <= (w_dec_new == 4'd1) ? 4'd0 : 4'd1;
            end else begin
                r_phase   <= (r_phase + 4'd1 == r_dec_cur) ? 4'd0 : r_phase + 4'd1;
            end
        end
    end

    // One extra bit keeps the rounding add from wrapping at full-scale input.
    assign w_sum    = {1'b0, in_data} + SUM_W'(rnd_bias(SHIFT));
    assign w_scaled = w_sum >> SHIFT;
    assign w_sat    = (w_scaled > SUM_W'(sat_max(OUT_W)));
    assign w_y      = w_sat ? {OUT_W{1'b1}} : w_scaled[OUT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_vld  <= 1'b0;
            r_stg_data <= '0;
            r_stg_sat  <= 1'b0;
        end else begin
            r_stg_vld <= w_keep;
            if (w_keep) begin
                r_stg_data <= w_y;
                r_stg_sat  <= w_sat;
            end
        end
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (r_stg_vld),
        .i_pop     (out_ready),
        .i_wdata   (r_stg_data),
        .o_rdata   (out_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level),
        .o_push_ok (w_push_ok),
        .o_drop    (w_drop)
    );

    assign out_valid = !w_empty;

    // A new event in the same cycle as clear wins, so nothing is silently lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_sat <= (r_sat && !clear_flags) || (r_stg_vld && r_stg_sat);
            r_ovf <= (r_ovf && !clear_flags) || w_drop;
        end
    end

    assign sat_flag = r_sat;
    assign ovf_flag = r_ovf;

`ifdef FIR_OUT_PEAK_EN
    logic [OUT_W-1:0] r_peak;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_peak <= '0;
        else if (clear_flags)
            r_peak <= w_push_ok ? r_stg_data : '0;
        else if (w_push_ok && r_stg_data > r_peak)
            r_peak <= r_stg_data;
    end

    assign peak_out = r_peak;
`else
    logic w_unused_full;
    assign w_unused_full = w_full ^ w_push_ok;
    assign peak_out      = '0;
`endif

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Directed bench for fir_out_conditioner with hand-computed expectations.
module tb_fir_out_conditioner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  dec_factor;
    logic        clear_flags;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  level;
    logic        sat_flag;
    logic        ovf_flag;
    logic [15:0] peak_out;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];

    fir_out_conditioner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .dec_factor  (dec_factor),
        .clear_flags (clear_flags),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .sat_flag    (sat_flag),
        .ovf_flag    (ovf_flag),
        .peak_out    (peak_out)
    );

    always #5 clk = ~clk;

    // Record every accepted head word; sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) q.push_back(int'(out_data));
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d exp %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int qget(input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int exp_q[$];
        reset_n     = 1'b0;
        enable      = 1'b0;
        dec_factor  = 4'd1;
        clear_flags = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        tick(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_sat",   sat_flag, 0);
        chk("rst_ovf",   ovf_flag, 0);
        chk("rst_peak",  peak_out, 0);
        reset_n = 1'b1;
        tick();

        // settle discard, then 2-cycle latency
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) feed(32'd12800);
        tick(3);
        chk("settle_level", level, 0);
        chk("settle_q", q.size(), 0);
        feed(32'd12800);
        chk("lat_k_valid", out_valid, 0);
        tick();
        chk("lat_k1_valid", out_valid, 1);
        chk("lat_k1_data", out_data, 100);
        tick(2);
        chk("lat_q", qget(0), 100);
        q.delete();

        // rounding at the half-LSB boundary
        feed(32'd191); feed(32'd192); feed(32'd63); feed(32'd64);
        tick(4);
        chk("rnd_n", q.size(), 4);
        chk("rnd_191", qget(0), 1);
        chk("rnd_192", qget(1), 2);
        chk("rnd_63",  qget(2), 0);
        chk("rnd_64",  qget(3), 1);
        q.delete();

        // saturation and flag clear
        feed(32'hFFFF_FFFF);
        tick(3);
        chk("sat_data", qget(0), 65535);
        chk("sat_flag", sat_flag, 1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("sat_clr", sat_flag, 0);
        q.delete();

        // decimation by 3
        dec_factor = 4'd3;
        for (int k = 1; k <= 9; k++) feed(32'(k * 128));
        tick(4);
        chk("dec_n", q.size(), 3);
        chk("dec_0", qget(0), 1);
        chk("dec_1", qget(1), 4);
        chk("dec_2", qget(2), 7);
        dec_factor = 4'd1;
        q.delete();

        // backpressure and overflow
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) feed(32'(k * 128));
        tick(2);
        chk("bp_level", level, 8);
        chk("bp_ovf", ovf_flag, 1);
        chk("bp_head", out_data, 1);
        chk("bp_q", q.size(), 0);
        out_ready = 1'b1;
        tick(10);
        chk("bp_level0", level, 0);
        chk("bp_n", q.size(), 8);
        for (int i = 0; i < 8; i++) exp_q.push_back(i + 1);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_q%0d", i), qget(i), exp_q[i]);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("ovf_clr", ovf_flag, 0);
        q.delete();

        // async reset mid-stream
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) feed(32'(k * 128));
        tick(2);
        chk("rs_level5", level, 5);
        reset_n = 1'b0;
        tick();
        chk("rs_level0", level, 0);
        chk("rs_valid", out_valid, 0);
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // disable/re-enable restarts settle; peak tracking
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) feed(32'd6400);
        tick(3);
        chk("re_settle_q", q.size(), 0);
        feed(32'd128); feed(32'd640); feed(32'd256);
        tick(4);
        chk("re_n", q.size(), 3);
        chk("re_0", qget(0), 1);
        chk("re_1", qget(1), 5);
        chk("re_2", qget(2), 2);
`ifdef FIR_OUT_PEAK_EN
        chk("peak", peak_out, 5);
`else
        chk("peak", peak_out, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
